// File: rtl/fpu_sp_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_sp_issue_ctrl
//   Initiator side of the single-precision FPU din1/din2/dval -> result/rdy
//   handshake. Add / sub / reverse-sub commands are buffered in a small FIFO
//   and issued one at a time to a single adder; subtraction is done by
//   flipping the sign of the subtrahend. Each result (or an error response on
//   illegal op / FPU timeout) is returned on a valid/ready response port, in
//   command order.
//
// Ports
//   clk, rst_n                     clock (posedge), async active-low reset
//   cmd_valid/cmd_ready            command handshake (ready = FIFO not full)
//   cmd_op[1:0], cmd_a, cmd_b      00 A+B, 01 A-B, 10 B-A, 11 illegal
//   fpu_din1, fpu_din2, fpu_dval   registered operands + one-cycle issue pulse
//   fpu_result, fpu_rdy            result from the FPU
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_err              result, or quiet NaN with err=1
//   busy                           FSM active or commands queued
// ---------------------------------------------------------------------------
module fpu_sp_issue_ctrl #(
    parameter int nBITS   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [nBITS-1:0] cmd_a,
    input  logic [nBITS-1:0] cmd_b,
    output logic [nBITS-1:0] fpu_din1,
    output logic [nBITS-1:0] fpu_din2,
    output logic             fpu_dval,
    input  logic [nBITS-1:0] fpu_result,
    input  logic             fpu_rdy,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [nBITS-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [nBITS-1:0] QNAN     = nBITS'(32'h7FC0_0000);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // FIFO storage (no reset needed: only entries below r_count are ever read)
    logic [1:0]       r_op_mem [DEPTH];
    logic [nBITS-1:0] r_a_mem  [DEPTH];
    logic [nBITS-1:0] r_b_mem  [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    state_t           r_state;
    state_t           w_state_next;
    logic [TW-1:0]    r_timer;
    logic [nBITS-1:0] r_din1;
    logic [nBITS-1:0] r_din2;
    logic [nBITS-1:0] r_rsp_data;
    logic             r_rsp_err;

    logic             w_push;
    logic             w_pop;
    logic             w_load_ops;
    logic             w_set_rsp;
    logic [nBITS-1:0] w_rsp_data_next;
    logic             w_rsp_err_next;
    logic [nBITS-1:0] w_din1_next;
    logic [nBITS-1:0] w_din2_next;
    logic [1:0]       w_head_op;
    logic [nBITS-1:0] w_head_a;
    logic [nBITS-1:0] w_head_b;

    assign cmd_ready = (r_count != FULL_CNT);
    assign w_push    = cmd_valid && cmd_ready;
    // The head entry stays in the FIFO until its response is accepted.
    assign w_pop     = (r_state == S_RESP) && rsp_ready;

    assign w_head_op = r_op_mem[r_rd_ptr];
    assign w_head_a  = r_a_mem[r_rd_ptr];
    assign w_head_b  = r_b_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr] <= cmd_op;
            r_a_mem[r_wr_ptr]  <= cmd_a;
            r_b_mem[r_wr_ptr]  <= cmd_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Subtraction is addition with the subtrahend's sign bit inverted.
    always_comb begin
        w_din1_next = w_head_a;
        w_din2_next = w_head_b;
        case (w_head_op)
            2'b01: begin
                w_din1_next = w_head_a;
                w_din2_next = {~w_head_b[nBITS-1], w_head_b[nBITS-2:0]};
            end
            2'b10: begin
                w_din1_next = w_head_b;
                w_din2_next = {~w_head_a[nBITS-1], w_head_a[nBITS-2:0]};
            end
            default: begin
                w_din1_next = w_head_a;
                w_din2_next = w_head_b;
            end
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_load_ops      = 1'b0;
        w_set_rsp       = 1'b0;
        w_rsp_data_next = r_rsp_data;
        w_rsp_err_next  = r_rsp_err;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    if (w_head_op == 2'b11) begin
                        w_state_next    = S_RESP;
                        w_set_rsp       = 1'b1;
                        w_rsp_data_next = QNAN;
                        w_rsp_err_next  = 1'b1;
                    end else begin
                        w_state_next = S_ISSUE;
                        w_load_ops   = 1'b1;
                    end
                end
            end
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT: begin
                // A result arriving on the last timer cycle still counts.
                if (fpu_rdy) begin
                    w_state_next    = S_RESP;
                    w_set_rsp       = 1'b1;
                    w_rsp_data_next = fpu_result;
                    w_rsp_err_next  = 1'b0;
                end else if (r_timer == TMO_LAST) begin
                    w_state_next    = S_RESP;
                    w_set_rsp       = 1'b1;
                    w_rsp_data_next = QNAN;
                    w_rsp_err_next  = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_din1     <= '0;
            r_din2     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_ISSUE)     r_timer <= '0;
            else if (r_state == S_WAIT) r_timer <= r_timer + TW'(1);
            if (w_load_ops) begin
                r_din1 <= w_din1_next;
                r_din2 <= w_din2_next;
            end
            if (w_set_rsp) begin
                r_rsp_data <= w_rsp_data_next;
                r_rsp_err  <= w_rsp_err_next;
            end
        end
    end

    assign fpu_din1  = r_din1;
    assign fpu_din2  = r_din2;
    assign fpu_dval  = (r_state == S_ISSUE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != S_IDLE) || (r_count != '0);

endmodule
